// File: rtl/sfll_adder_pipe.sv
// Two-stage pipelined half-word adder with an SFLL-HD0 perturb/restore unit.
// The restore key is shifted in serially (LSB first) and armed by a small FSM.
module sfll_adder_pipe #(
    parameter int IN_W = 8,
    localparam int OUT_W = IN_W / 2 + 1,
    localparam int CNT_W = $clog2(IN_W + 1),
    parameter logic [IN_W-1:0]  PROT_PATTERN = {{(IN_W-1){1'b0}}, 1'b1},
    parameter logic [OUT_W-1:0] FLIP_MASK    = {{(OUT_W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             key_shift,
    input  logic             key_bit,
    input  logic             key_clear,
    output logic             key_armed
);

    localparam int HALF_W = IN_W / 2;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2
    } key_state_t;

    key_state_t         state_r;
    logic [IN_W-1:0]    key_reg_r;
    logic [CNT_W-1:0]   key_cnt_r;
    logic               key_armed_r;

    logic               s1_valid_r;
    logic [IN_W-1:0]    s1_data_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_data_r;

    logic               advance_s;
    logic [HALF_W-1:0]  a_s;
    logic [HALF_W-1:0]  b_s;
    logic [OUT_W-1:0]   sum_s;
    logic               pert_s;
    logic               rest_s;
    logic [OUT_W-1:0]   result_s;

    // Key loading FSM; clear has priority over shift, and an armed key is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOCKED;
            key_reg_r   <= {IN_W{1'b0}};
            key_cnt_r   <= {CNT_W{1'b0}};
            key_armed_r <= 1'b0;
        end else if (key_clear) begin
            state_r     <= ST_LOCKED;
            key_reg_r   <= {IN_W{1'b0}};
            key_cnt_r   <= {CNT_W{1'b0}};
            key_armed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    if (key_shift) begin
                        key_reg_r <= {key_bit, key_reg_r[IN_W-1:1]};
                        key_cnt_r <= CNT_W'(1);
                        state_r   <= ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (key_shift) begin
                        key_reg_r <= {key_bit, key_reg_r[IN_W-1:1]};
                        key_cnt_r <= key_cnt_r + CNT_W'(1);
                        if (key_cnt_r == CNT_W'(IN_W - 1)) begin
                            state_r     <= ST_ARMED;
                            key_armed_r <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    key_armed_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_LOCKED;
                    key_reg_r   <= {IN_W{1'b0}};
                    key_cnt_r   <= {CNT_W{1'b0}};
                    key_armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage-2 datapath: sum of the halves, inverted on FLIP_MASK when exactly one of perturb/restore fires.
    always_comb begin
        a_s      = s1_data_r[HALF_W-1:0];
        b_s      = s1_data_r[IN_W-1:HALF_W];
        sum_s    = {1'b0, a_s} + {1'b0, b_s};
        pert_s   = (s1_data_r == PROT_PATTERN);
        rest_s   = key_armed_r & (s1_data_r == key_reg_r);
        result_s = sum_s ^ (FLIP_MASK & {OUT_W{pert_s ^ rest_s}});
    end

    assign advance_s = !out_valid_r | out_ready;

    // Two-stage pipeline; every stage holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_data_r   <= {IN_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else if (advance_s) begin
            s1_valid_r  <= in_valid;
            out_valid_r <= s1_valid_r;
            if (in_valid) begin
                s1_data_r <= in_data;
            end
            if (s1_valid_r) begin
                out_data_r <= result_s;
            end
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign key_armed = key_armed_r;

endmodule

// File: tb/tb_sfll_adder_pipe.sv
// Directed bench for sfll_adder_pipe: locking behaviour, key FSM, stalls and reset.
module tb_sfll_adder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       key_shift;
    logic       key_bit;
    logic       key_clear;
    logic       key_armed;

    int n_checks = 0;
    int n_pass   = 0;

    sfll_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .key_shift (key_shift),
        .key_bit   (key_bit),
        .key_clear (key_clear),
        .key_armed (key_armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [7:0] d, input logic [4:0] want, input string tag);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 6) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, 2);
        check(tag, out_data, want);
        step();
    endtask

    task automatic load_key(input logic [7:0] k, input string tag);
        for (int i = 0; i < 8; i++) begin
            key_shift = 1'b1;
            key_bit   = k[i];
            step();
            check($sformatf("%s_arm%0d", tag, i), key_armed, (i == 7) ? 1 : 0);
        end
        key_shift = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic clear_key();
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
    endtask

    logic [7:0] vec   [4] = '{8'h00, 8'h11, 8'h0F, 8'hF0};
    logic [4:0] exp_v [4] = '{5'h00, 5'h02, 5'h0F, 5'h0F};

    initial begin
        int ii, io, stall;
        bit did_stall;
        logic [4:0] held;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        key_shift = 1'b0; key_bit = 1'b0; key_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", out_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_armed", key_armed, 0);
        check("rst_iready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Locked: protected cube is corrupted, others are not.
        send_one(8'h01, 5'h00, "lock_01");
        check("lock_armed", key_armed, 0);
        send_one(8'h35, 5'h08, "lock_35");

        // Correct key restores function.
        load_key(8'h01, "kc");
        send_one(8'h01, 5'h01, "ok_01");
        send_one(8'hFF, 5'h1E, "ok_FF");
        // Shifts while armed must not alter the key.
        for (int i = 0; i < 3; i++) begin
            key_shift = 1'b1; key_bit = 1'b1; step();
        end
        key_shift = 1'b0;
        check("armed_hold", key_armed, 1);
        send_one(8'h01, 5'h01, "ok_01b");

        // Wrong key: corruption at both the key and the protected cube.
        clear_key();
        check("clr_armed", key_armed, 0);
        load_key(8'h35, "kw");
        send_one(8'h35, 5'h09, "wk_35");
        send_one(8'h01, 5'h00, "wk_01");
        send_one(8'h22, 5'h04, "wk_22");

        // Clear wins over shift while armed.
        key_clear = 1'b1; key_shift = 1'b1; key_bit = 1'b1;
        step();
        key_clear = 1'b0; key_shift = 1'b0; key_bit = 1'b0;
        check("cs_armed", key_armed, 0);
        send_one(8'h01, 5'h00, "cs_01");
        send_one(8'h35, 5'h08, "cs_35");

        // Back-to-back stream with a 3-cycle stall on the second result.
        ii = 0; io = 0; stall = 0; did_stall = 1'b0; held = 5'h00;
        for (int cyc = 0; cyc < 30 && io < 4; cyc++) begin
            if (out_valid && io == 1 && !did_stall) begin
                did_stall = 1'b1;
                stall = 3;
                held = out_data;
            end
            out_ready = (stall == 0);
            in_valid  = (ii < 4);
            in_data   = (ii < 4) ? vec[ii] : 8'h00;
            #1;
            if (stall > 0) begin
                check("stall_iready", in_ready, 0);
                check("stall_hold", out_data, held);
                check("stall_ovalid", out_valid, 1);
                stall--;
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d", io), out_data, exp_v[io]);
                io++;
            end
            if (in_valid && in_ready) ii++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_cnt", io, 4);
        check("stream_did_stall", did_stall, 1);
        step();
        check("stream_nodup", out_valid, 0);

        // Reset mid-load with two results in flight.
        load_key(8'h01, "kr");
        clear_key();
        for (int i = 0; i < 4; i++) begin
            key_shift = 1'b1; key_bit = 1'b1; step();
        end
        key_shift = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        step();
        in_data = 8'h22;
        step();
        in_valid = 1'b0;
        check("pre_rst_ovalid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", out_valid, 0);
        check("mid_rst_odata", out_data, 0);
        check("mid_rst_armed", key_armed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst_ovalid%0d", i), out_valid, 0);
        end
        load_key(8'h01, "kpost");
        send_one(8'h01, 5'h01, "post_01");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfll_adder_pipe.md
Name: sfll_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's single-output point-function-locked nibble adder.
- Adds the two halves of an IN_W-bit operand word. A perturb/restore point-function unit (SFLL-HD0 style) is applied on a selectable mask of sum bits.
- The locking key is a serially loaded register, armed by a small FSM.
- Sits behind the locking framework's key-delivery scan path; feeds downstream datapath through a valid/ready handshake.

Parameters:
- IN_W, 8, operand word width; must be even and >= 4; halves A = in_data[IN_W/2-1:0], B = in_data[IN_W-1:IN_W/2].
- OUT_W, IN_W/2+1, derived sum width; not overridable.
- PROT_PATTERN, 8'h01 (IN_W bits), protected input cube; the correct key equals this value.
- FLIP_MASK, 1 (OUT_W bits), sum bits inverted when the flip signal is asserted.
- CNT_W, $clog2(IN_W+1), derived key-load counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block accepts an operand this cycle.
- in_data  in  IN_W  operand word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  (possibly corrupted) sum.
- key_shift  in  1  shift one key bit in this cycle.
- key_bit  in  1  serial key bit, LSB first.
- key_clear  in  1  zero the key and return to LOCKED.
- key_armed  out  1  key fully loaded; restore unit enabled.

Behaviour:
- Reset (async assert, sync release): key_reg=0, key_cnt=0, FSM=LOCKED, both pipeline stages invalid, out_valid=0, out_data=0, key_armed=0. in_ready=1 after reset.

FSM:
- LOCKED: key_shift -> LOADING; the first bit is shifted in and key_cnt=1.
- LOADING: each key_shift does key_reg <= {key_bit, key_reg[IN_W-1:1]} and key_cnt++.
  - When the shift that makes key_cnt==IN_W occurs -> ARMED next cycle.
  - Cycles without key_shift hold state.
- ARMED: key_armed=1; key_shift is ignored (the key cannot be altered without a clear).
- key_clear in any state -> key_reg=0, key_cnt=0, LOCKED next cycle. key_clear beats key_shift in the same cycle.

Pipeline (latency 2, one result per cycle at full throughput):
- advance = !out_valid | out_ready; in_ready = advance.
- Stage 1: on advance, s1_valid<=in_valid and s1_data<=in_data (data captured only when in_valid).
- Stage 2: on advance, out_valid<=s1_valid. When s1_valid, out_data <= (A+B) ^ (FLIP_MASK & {OUT_W{pert ^ rest}}), where:
  - pert = (s1_data == PROT_PATTERN)
  - rest = key_armed & (s1_data == key_reg)
- key_reg and key_armed are sampled at the stage-2 capture edge. A key change affects only results captured after that edge.
- Stall (out_valid & !out_ready): all stages hold; out_data stable; in_ready=0.
- Arithmetic: unsigned, A+B zero-extended to OUT_W; the carry is out_data[OUT_W-1]; no truncation.
- Correct key (key_reg==PROT_PATTERN, ARMED): pert==rest for every input, so out_data = A+B exactly.
- Not armed: output is corrupted only at in_data==PROT_PATTERN.
- Armed with wrong key K: output is corrupted at both PROT_PATTERN and K.
- Reset mid-operation clears in-flight results; no output is produced for them.

Test Plan:
- Reset, no key, in_data=0x01 with out_ready=1 -> out_valid rises 2 cycles later with out_data=5'h00 (flipped); key_armed=0.
- Shift key 0x01 LSB first over 8 cycles -> key_armed=1 on the cycle after the 8th shift. Then in_data=0x01 -> 5'h01 and in_data=0xFF -> 5'h1E.
- Load wrong key 0x35 -> in_data=0x35 gives 5'h09 (true 5'h08); in_data=0x01 gives 5'h00; in_data=0x22 gives 5'h04.
- Back-to-back stream 0x00,0x11,0x0F,0xF0 with out_ready low on the 2nd result for 3 cycles -> results 0x00,0x02,0x0F,0x0F in order, none lost or duplicated; out_data held while stalled; in_ready=0 during the stall.
- key_clear asserted together with key_shift while ARMED -> LOCKED next cycle, key_reg=0, key_armed=0; in_data=0x01 then yields 5'h00.
- rst_n pulsed low mid-load (after 4 shifts) and with 2 results in flight -> outputs return to reset values immediately; no stale out_valid after release; a reload requires 8 fresh shifts.
